// File: rtl/source_fsm.sv
// Serial "101" detector (overlapping) with exported one-hot state/next-state
// and a 3-bit wrap-around count of completed detections.
module source_fsm (
  output logic [2:0] y,
  output logic [3:0] n,
  output logic [3:0] s,
  input  logic       a,
  input  logic       rst,
  input  logic       clk
);

  typedef enum logic [3:0] {
    S0 = 4'b0001,
    S1 = 4'b0010,
    S2 = 4'b0100,
    S3 = 4'b1000
  } state_e;

  // Kept as a plain vector so illegal encodings can exist and be recovered from.
  logic [3:0] s_q, n_d;
  logic [2:0] y_q, y_d;

  always_comb begin
    n_d = S0;
    y_d = y_q;
    case (s_q)
      S0:      n_d = a ? S1 : S0;
      S1:      n_d = a ? S1 : S2;
      S2:      n_d = a ? S3 : S0;
      S3:      n_d = a ? S1 : S2;
      default: n_d = S0;
    endcase
    if (n_d == S3) y_d = y_q + 3'd1;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      s_q <= S0;
      y_q <= 3'd0;
    end else begin
      s_q <= n_d;
      y_q <= y_d;
    end
  end

  assign s = s_q;
  assign n = n_d;
  assign y = y_q;

endmodule

// File: tb/tb_source_fsm.sv
// Scoreboard bench for source_fsm: a history-based reference of the "101"
// detector pushes expected {s,y}; each task pops and checks after every edge.
module tb_source_fsm;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       a   = 1'b0;
  logic [2:0] y;
  logic [3:0] n;
  logic [3:0] s;

  int tests  = 0;
  int failed = 0;

  logic [2:0] hist = 3'b000;
  logic [2:0] cnt  = 3'd0;
  logic [6:0] exp_q[$];
  logic [6:0] exp_v;

  source_fsm dut (.y(y), .n(n), .s(s), .a(a), .rst(rst), .clk(clk));

  always #5 clk = ~clk;

  // Reference: state follows from the last three sampled bits since reset.
  function automatic logic [3:0] hist_state(input logic [2:0] h);
    if (h == 3'b101)     return 4'b1000;
    if (h[1:0] == 2'b10) return 4'b0100;
    if (h[0])            return 4'b0010;
    return 4'b0001;
  endfunction

  // Drive one cycle of stimulus, push expectation, then wait past the edge.
  task automatic step(input logic a_v, input logic rst_v);
    logic [3:0] es;
    @(negedge clk);
    a   = a_v;
    rst = rst_v;
    if (!rst_v) begin
      hist = 3'b000;
      cnt  = 3'd0;
      es   = 4'b0001;
    end else begin
      hist = {hist[1:0], a_v};
      es   = hist_state(hist);
      if (es == 4'b1000) cnt = cnt + 3'd1;
    end
    exp_q.push_back({es, cnt});
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    step(1'b1, 1'b1);
    step(1'b0, 1'b1);
    step(1'b1, 1'b1);
    void'(exp_q.pop_front()); void'(exp_q.pop_front()); void'(exp_q.pop_front());
    step(1'b1, 1'b0);
    exp_v = exp_q.pop_front();
    tests++; if (s !== 4'b0001) begin failed++; $display("FAIL reset_s got %b want 0001", s); end
    tests++; if (y !== 3'd0) begin failed++; $display("FAIL reset_y got %0d want 0", y); end
    tests++; if (n !== 4'b0010) begin failed++; $display("FAIL reset_n_a1 got %b want 0010", n); end
    tests++; if ({s, y} !== exp_v) begin failed++; $display("FAIL reset_sb got %b want %b", {s, y}, exp_v); end
  endtask

  task automatic test_basic();
    logic       av[9] = '{0, 0, 1, 0, 1, 1, 1, 0, 1};
    logic [3:0] sv[9] = '{4'b0001, 4'b0001, 4'b0010, 4'b0100, 4'b1000,
                          4'b0010, 4'b0010, 4'b0100, 4'b1000};
    logic [2:0] yv[9] = '{0, 0, 0, 0, 1, 1, 1, 1, 2};
    step(1'b0, 1'b0); void'(exp_q.pop_front());
    for (int i = 0; i < 9; i++) begin
      step(av[i], 1'b1);
      exp_v = exp_q.pop_front();
      tests++; if (s !== sv[i]) begin failed++; $display("FAIL basic_s[%0d] got %b want %b", i, s, sv[i]); end
      tests++; if (y !== yv[i]) begin failed++; $display("FAIL basic_y[%0d] got %0d want %0d", i, y, yv[i]); end
      tests++; if ({s, y} !== exp_v) begin failed++; $display("FAIL basic_sb[%0d] got %b want %b", i, {s, y}, exp_v); end
    end
  endtask

  task automatic test_overlap();
    logic av[7] = '{1, 0, 1, 0, 1, 0, 1};
    int   hits = 0;
    step(1'b0, 1'b0); void'(exp_q.pop_front());
    for (int i = 0; i < 7; i++) begin
      step(av[i], 1'b1);
      exp_v = exp_q.pop_front();
      if (s === 4'b1000) hits++;
      tests++; if ({s, y} !== exp_v) begin failed++; $display("FAIL overlap_sb[%0d] got %b want %b", i, {s, y}, exp_v); end
    end
    tests++; if (hits != 3) begin failed++; $display("FAIL overlap_hits got %0d want 3", hits); end
    tests++; if (y !== 3'd3) begin failed++; $display("FAIL overlap_y got %0d want 3", y); end
  endtask

  task automatic test_wrap();
    step(1'b0, 1'b0); void'(exp_q.pop_front());
    step(1'b1, 1'b1); void'(exp_q.pop_front());
    for (int d = 1; d <= 8; d++) begin
      step(1'b0, 1'b1); void'(exp_q.pop_front());
      step(1'b1, 1'b1);
      exp_v = exp_q.pop_front();
      tests++; if ({s, y} !== exp_v) begin failed++; $display("FAIL wrap_sb[%0d] got %b want %b", d, {s, y}, exp_v); end
      if (d == 7) begin
        tests++; if (y !== 3'd7) begin failed++; $display("FAIL wrap_y7 got %0d want 7", y); end
      end
    end
    tests++; if (y !== 3'd0) begin failed++; $display("FAIL wrap_y0 got %0d want 0", y); end
  endtask

  task automatic test_mid_reset();
    step(1'b0, 1'b0); void'(exp_q.pop_front());
    step(1'b1, 1'b1); void'(exp_q.pop_front());
    for (int d = 0; d < 5; d++) begin
      step(1'b0, 1'b1); void'(exp_q.pop_front());
      step(1'b1, 1'b1); void'(exp_q.pop_front());
    end
    step(1'b0, 1'b1); void'(exp_q.pop_front());
    tests++; if ({s, y} !== {4'b0100, 3'd5}) begin failed++; $display("FAIL midrst_pre got %b want 0100101", {s, y}); end
    step(1'b1, 1'b0);
    exp_v = exp_q.pop_front();
    tests++; if ({s, y} !== {4'b0001, 3'd0}) begin failed++; $display("FAIL midrst_post got %b want 0001000", {s, y}); end
    tests++; if ({s, y} !== exp_v) begin failed++; $display("FAIL midrst_sb got %b want %b", {s, y}, exp_v); end
  endtask

  task automatic test_illegal();
    step(1'b0, 1'b0); void'(exp_q.pop_front());
    @(negedge clk);
    rst = 1'b1;
    a   = 1'b0;
    force dut.s_q = 4'b0110;
    #1;
    tests++; if (n !== 4'b0001) begin failed++; $display("FAIL illegal_n_a0 got %b want 0001", n); end
    a = 1'b1;
    #1;
    tests++; if (n !== 4'b0001) begin failed++; $display("FAIL illegal_n_a1 got %b want 0001", n); end
    a = 1'b0;
    #1;
    release dut.s_q;
    @(posedge clk);
    #1;
    tests++; if (s !== 4'b0001) begin failed++; $display("FAIL illegal_recover got %b want 0001", s); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_overlap();
    test_wrap();
    test_mid_reset();
    test_illegal();
    tests++; if (exp_q.size() != 0) begin failed++; $display("FAIL sb_leftover got %0d want 0", exp_q.size()); end
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
